// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Single-stage 16-bit instruction decoder with valid/ready
//                handshake, registered outputs, immediate extension and a
//                count of delivered instructions.
//                Optional macro DECODE_SKID_EN adds a one-entry skid buffer
//                so that in_ready becomes a pure register output.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int IMM_W      = 16,
  parameter int IMM_SIGNED = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_opcode,
  output logic [2:0]       out_rx,
  output logic [2:0]       out_ry,
  output logic [2:0]       out_rz,
  output logic [2:0]       out_func,
  output logic [IMM_W-1:0] out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_count
);

  localparam bit c_sext = (IMM_SIGNED != 0);

  // Output-stage registers
  logic             r_out_valid;
  logic [1:0]       r_opcode;
  logic [2:0]       r_rx;
  logic [2:0]       r_ry;
  logic [2:0]       r_rz;
  logic [2:0]       r_func;
  logic [IMM_W-1:0] r_imm;
  logic             r_illegal;
  logic [CNT_W-1:0] r_dec_count;

  // Handshake and decode wires
  logic             w_xfer;
  logic             w_out_free;
  logic             w_accept;
  logic             w_load_out;
  logic [15:0]      w_src_word;
  logic [1:0]       w_opcode;
  logic [2:0]       w_func;
  logic [IMM_W-1:0] w_imm;
  logic             w_illegal;

  assign w_xfer     = r_out_valid && out_ready;
  assign w_out_free = !r_out_valid || out_ready;

`ifdef DECODE_SKID_EN
  // Skid buffer: holds one raw word accepted while the output was stalled.
  logic        r_skid_valid;
  logic [15:0] r_skid_word;
  logic        r_in_ready;
  logic        w_park;
  logic        w_skid_valid_nxt;

  assign in_ready   = r_in_ready;
  assign w_accept   = in_valid && r_in_ready && !flush;
  assign w_park     = w_accept && !w_out_free;
  // The parked word is older than anything on in_word, so it goes first.
  assign w_load_out = !flush && w_out_free && (r_skid_valid || w_accept);
  assign w_src_word = r_skid_valid ? r_skid_word : in_word;

  // Next skid occupancy; in_ready is registered from it to cut any
  // combinational path from out_ready.
  always_comb begin
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_skid_valid_nxt = 1'b0;
    end else if (r_skid_valid && w_out_free) begin
      w_skid_valid_nxt = 1'b0;
    end else if (w_park) begin
      w_skid_valid_nxt = 1'b1;
    end
  end

  // Skid storage and registered ready (held low throughout reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
      r_skid_word  <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      if (w_park) begin
        r_skid_word <= in_word;
      end
    end
  end
`else
  // Without a skid the stage accepts whenever the output slot frees up.
  logic r_ready_en;

  assign in_ready   = r_ready_en && w_out_free;
  assign w_accept   = in_valid && in_ready && !flush;
  assign w_load_out = w_accept;
  assign w_src_word = in_word;

  // Keeps in_ready low during reset and releases it on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end
`endif

  assign w_opcode  = w_src_word[1:0];
  assign w_func    = w_src_word[7:5];
  assign w_illegal = (w_opcode == 2'd0) && (w_func == 3'b111);

  // Immediate extraction; every raw immediate has word[15] as its MSB, so
  // the fill value is word[15] when sign-extending.
  always_comb begin
    w_imm = {IMM_W{c_sext && w_src_word[15]}};
    case (w_opcode)
      2'd1:    w_imm[4:0]  = w_src_word[15:11];
      2'd2:    w_imm[10:0] = w_src_word[15:5];
      2'd3:    w_imm[7:0]  = {w_src_word[15:14], w_src_word[7:2]};
      default: w_imm       = '0;
    endcase
  end

  // Output valid: flush wins, then a new load, then a plain drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load_out) begin
      r_out_valid <= 1'b1;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // Decoded fields only change on a load, so they hold during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode  <= '0;
      r_rx      <= '0;
      r_ry      <= '0;
      r_rz      <= '0;
      r_func    <= '0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
    end else if (w_load_out) begin
      r_opcode  <= w_opcode;
      r_rx      <= w_src_word[10:8];
      r_ry      <= w_src_word[13:11];
      r_rz      <= w_src_word[4:2];
      r_func    <= w_func;
      r_imm     <= w_imm;
      r_illegal <= w_illegal;
    end
  end

  // Delivered-instruction counter; a transfer coincident with flush counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_count <= '0;
    end else if (w_xfer) begin
      r_dec_count <= r_dec_count + 1'b1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_opcode  = r_opcode;
  assign out_rx      = r_rx;
  assign out_ry      = r_ry;
  assign out_rz      = r_rz;
  assign out_func    = r_func;
  assign out_imm     = r_imm;
  assign out_illegal = r_illegal;
  assign dec_count   = r_dec_count;

endmodule
`default_nettype wire
